// File: rtl/fpu_wb_pkg.sv
// Shared types and the IEEE lane packing helper for the FPU writeback arbiter.
// Bundle layout mirrors the flattened per-source request ports.
package fpu_wb_pkg;

    localparam int SRC_N    = 2;
    localparam int INT_W    = 53;
    localparam int EXP_W    = 11;
    localparam int REG_SIZE = 64;
    localparam int FLAG_W   = 8;

    localparam int FLAG_SIGNA = 7;
    localparam int FLAG_SIGNB = 6;
    localparam int FLAG_NANA  = 5;
    localparam int FLAG_NANB  = 4;
    localparam int FLAG_INFA  = 3;
    localparam int FLAG_INFB  = 2;
    localparam int FLAG_ERRA  = 1;
    localparam int FLAG_ERRB  = 0;

    typedef struct packed {
        logic              mode;
        logic [INT_W-1:0]  intA;
        logic [INT_W-1:0]  intB;
        logic [EXP_W-1:0]  expA;
        logic [EXP_W-1:0]  expB;
        logic [FLAG_W-1:0] flags;
    } fpu_res_t;

    // Significand carries an explicit hidden bit, so only the fraction bits are packed.
    function automatic logic [REG_SIZE-1:0] pack_lane(
        input logic             mode,
        input logic             sign,
        input logic             nan,
        input logic             inf,
        input logic [INT_W-1:0] sig,
        input logic [EXP_W-1:0] ex
    );
        logic [REG_SIZE-1:0] lane;
        if (mode) begin
            if (nan)      lane = {sign, 11'h7FF, 1'b1, 51'd0};
            else if (inf) lane = {sign, 11'h7FF, 52'd0};
            else          lane = {sign, ex, sig[51:0]};
        end else begin
            if (nan)      lane = {32'd0, sign, 8'hFF, 1'b1, 22'd0};
            else if (inf) lane = {32'd0, sign, 8'hFF, 23'd0};
            else          lane = {32'd0, sign, ex[7:0], sig[22:0]};
        end
        return lane;
    endfunction

endpackage

// File: rtl/fpu_wb_arbiter_pack.sv
// OutputInterface: combinational packer from an unpacked FPU result to IEEE
// single/double lanes A and B, plus the combined error flag.
module OutputInterface
    import fpu_wb_pkg::*;
(
    input  logic                i_mode,
    input  logic [INT_W-1:0]    i_intA,
    input  logic [INT_W-1:0]    i_intB,
    input  logic [EXP_W-1:0]    i_expA,
    input  logic [EXP_W-1:0]    i_expB,
    input  logic [FLAG_W-1:0]   i_flags,
    output logic [REG_SIZE-1:0] o_outA,
    output logic [REG_SIZE-1:0] o_outB,
    output logic                o_err
);

    assign o_outA = pack_lane(i_mode, i_flags[FLAG_SIGNA], i_flags[FLAG_NANA],
                              i_flags[FLAG_INFA], i_intA, i_expA);
    assign o_outB = pack_lane(i_mode, i_flags[FLAG_SIGNB], i_flags[FLAG_NANB],
                              i_flags[FLAG_INFB], i_intB, i_expB);
    assign o_err  = i_flags[FLAG_ERRA] | i_flags[FLAG_ERRB];

endmodule

// File: rtl/fpu_wb_arbiter_rr.sv
// Two-way round-robin grant: a lone requester wins, on contention the source
// that was not served last wins. Grants are suppressed when i_adv is low.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_adv,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_adv) begin
            case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/fpu_wb_arbiter.sv
// Round-robin share of one OutputInterface packer between the add/sub and
// mul/div units, with a one-deep valid/ready output stage and error counters.
module fpu_wb_arbiter
    import fpu_wb_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SRC_N-1:0]          rq_valid,
    output logic [SRC_N-1:0]          rq_ready,
    input  logic [SRC_N-1:0]          rq_mode,
    input  logic [SRC_N*INT_W-1:0]    rq_intA,
    input  logic [SRC_N*INT_W-1:0]    rq_intB,
    input  logic [SRC_N*EXP_W-1:0]    rq_expA,
    input  logic [SRC_N*EXP_W-1:0]    rq_expB,
    input  logic [SRC_N*FLAG_W-1:0]   rq_flags,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REG_SIZE-1:0]       out_A,
    output logic [REG_SIZE-1:0]       out_B,
    output logic                      out_err,
    output logic                      out_src,
    input  logic                      clr_cnt,
    output logic [ERR_CNT_W-1:0]      err_cnt0,
    output logic [ERR_CNT_W-1:0]      err_cnt1
);

    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    logic                r_out_valid;
    logic [REG_SIZE-1:0] r_out_A;
    logic [REG_SIZE-1:0] r_out_B;
    logic                r_out_err;
    logic                r_out_src;
    logic                r_last;
    logic [ERR_CNT_W-1:0] r_err_cnt [SRC_N];

    fpu_res_t            w_res [SRC_N];
    fpu_res_t            w_win;
    logic                w_free;
    logic [SRC_N-1:0]    w_grant;
    logic                w_accept;
    logic                w_sel;
    logic [REG_SIZE-1:0] w_packA;
    logic [REG_SIZE-1:0] w_packB;
    logic                w_pack_err;

    for (genvar g = 0; g < SRC_N; g++) begin : g_bundle
        assign w_res[g] = {rq_mode[g],
                           rq_intA[g*INT_W +: INT_W], rq_intB[g*INT_W +: INT_W],
                           rq_expA[g*EXP_W +: EXP_W], rq_expB[g*EXP_W +: EXP_W],
                           rq_flags[g*FLAG_W +: FLAG_W]};
    end

    // Reset gates the handshake so no source sees ready while rst_n is low.
    assign w_free = rst_n & (~r_out_valid | out_ready);

    rr_arb2 u_arb (
        .i_valid (rq_valid),
        .i_adv   (w_free),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    assign rq_ready = w_grant;
    assign w_accept = |w_grant;
    assign w_sel    = w_grant[1];
    assign w_win    = w_sel ? w_res[1] : w_res[0];

    OutputInterface u_pack (
        .i_mode  (w_win.mode),
        .i_intA  (w_win.intA),
        .i_intB  (w_win.intB),
        .i_expA  (w_win.expA),
        .i_expB  (w_win.expB),
        .i_flags (w_win.flags),
        .o_outA  (w_packA),
        .o_outB  (w_packB),
        .o_err   (w_pack_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_A     <= '0;
            r_out_B     <= '0;
            r_out_err   <= 1'b0;
            r_out_src   <= 1'b0;
            r_last      <= 1'b1;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_A     <= w_packA;
            r_out_B     <= w_packB;
            r_out_err   <= w_pack_err;
            r_out_src   <= w_sel;
            r_last      <= w_sel;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Clear has priority over a same-cycle erroring accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '{default: '0};
        end else begin
            for (int i = 0; i < SRC_N; i++) begin
                if (clr_cnt)
                    r_err_cnt[i] <= '0;
                else if (w_grant[i] && w_pack_err && (r_err_cnt[i] != CNT_MAX))
                    r_err_cnt[i] <= r_err_cnt[i] + CNT_ONE;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_A     = r_out_A;
    assign out_B     = r_out_B;
    assign out_err   = r_out_err;
    assign out_src   = r_out_src;
    assign err_cnt0  = r_err_cnt[0];
    assign err_cnt1  = r_err_cnt[1];

endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// Scoreboard bench for fpu_wb_arbiter: directed bundles with hand-computed
// packed values, a grant model feeding an in-order expected queue.
module tb_fpu_wb_arbiter;

    typedef struct {
        logic        mode;
        logic [52:0] iA, iB;
        logic [10:0] eA, eB;
        logic [7:0]  fl;
        logic [63:0] oA, oB;
        logic        err;
    } vec_t;

    typedef struct {
        int idx;
        bit clr;
    } item_t;

    typedef struct {
        logic [63:0] oA, oB;
        logic        err;
        logic        src;
    } exp_t;

    logic         clk, rst_n;
    logic [1:0]   rq_valid, rq_ready, rq_mode;
    logic [105:0] rq_intA, rq_intB;
    logic [21:0]  rq_expA, rq_expB;
    logic [15:0]  rq_flags;
    logic         out_valid, out_ready, out_err, out_src, clr_cnt;
    logic [63:0]  out_A, out_B;
    logic [15:0]  err_cnt0, err_cnt1;

    logic [1:0]   rq_ready2;
    logic         out_valid2, out_err2, out_src2;
    logic [63:0]  out_A2, out_B2;
    logic [1:0]   err_cnt0_2, err_cnt1_2;

    vec_t  vec [8];
    item_t drv_q0[$], drv_q1[$];
    exp_t  sbq[$];
    int    src_log[$], cyc_log[$];
    bit [1:0] acc_seen;
    int    n_checks, n_fail, cyc;
    logic  m_last, m_ov;

    fpu_wb_arbiter #(.ERR_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_mode(rq_mode),
        .rq_intA(rq_intA), .rq_intB(rq_intB), .rq_expA(rq_expA), .rq_expB(rq_expB),
        .rq_flags(rq_flags), .out_valid(out_valid), .out_ready(out_ready), .out_A(out_A),
        .out_B(out_B), .out_err(out_err), .out_src(out_src), .clr_cnt(clr_cnt),
        .err_cnt0(err_cnt0), .err_cnt1(err_cnt1)
    );

    fpu_wb_arbiter #(.ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .rq_valid(rq_valid), .rq_ready(rq_ready2), .rq_mode(rq_mode),
        .rq_intA(rq_intA), .rq_intB(rq_intB), .rq_expA(rq_expA), .rq_expB(rq_expB),
        .rq_flags(rq_flags), .out_valid(out_valid2), .out_ready(out_ready), .out_A(out_A2),
        .out_B(out_B2), .out_err(out_err2), .out_src(out_src2), .clr_cnt(clr_cnt),
        .err_cnt0(err_cnt0_2), .err_cnt1(err_cnt1_2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load(input int s, input int idx, input bit clr);
        item_t it;
        it.idx = idx;
        it.clr = clr;
        if (s == 0) drv_q0.push_back(it);
        else        drv_q1.push_back(it);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((drv_q0.size() != 0 || drv_q1.size() != 0 || sbq.size() != 0 || out_valid)
               && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(name, 64'(n < budget), 64'd1);
        #2;
    endtask

    task automatic chk_seq(input string name, input int n, input logic [7:0] seq);
        chk({name, "_count"}, 64'(src_log.size()), 64'(n));
        for (int i = 0; i < n; i++)
            if (i < src_log.size()) chk(name, 64'(src_log[i]), 64'(seq[i]));
    endtask

    task automatic monitor_loop();
        exp_t        e;
        vec_t        v;
        logic        free;
        logic [1:0]  g;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_last = 1'b1;
                m_ov   = 1'b0;
                sbq.delete();
                acc_seen = 2'b00;
            end else begin
                chk("out_valid", out_valid, m_ov);
                chk("sat_out_valid", out_valid2, m_ov);
                if (m_ov && out_ready) begin
                    if (sbq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_empty: unexpected transfer out_A=%0h, expected none", out_A);
                    end else begin
                        e = sbq.pop_front();
                        chk("out_A", out_A, e.oA);
                        chk("out_B", out_B, e.oB);
                        chk("out_err", out_err, e.err);
                        chk("out_src", out_src, e.src);
                        chk("sat_out_A", out_A2, e.oA);
                        chk("sat_out_B", out_B2, e.oB);
                        chk("sat_out_err", out_err2, e.err);
                        chk("sat_out_src", out_src2, e.src);
                        src_log.push_back(int'(out_src));
                        cyc_log.push_back(cyc);
                    end
                end
                free = !m_ov || out_ready;
                case (rq_valid)
                    2'b01:   g = 2'b01;
                    2'b10:   g = 2'b10;
                    2'b11:   g = m_last ? 2'b01 : 2'b10;
                    default: g = 2'b00;
                endcase
                if (!free) g = 2'b00;
                chk("rq_ready", rq_ready, g);
                chk("sat_rq_ready", rq_ready2, g);
                if (g != 2'b00) begin
                    v = g[1] ? vec[drv_q1[0].idx] : vec[drv_q0[0].idx];
                    e.oA  = v.oA;
                    e.oB  = v.oB;
                    e.err = v.err;
                    e.src = g[1];
                    sbq.push_back(e);
                    m_last = g[1];
                    m_ov   = 1'b1;
                    acc_seen[g[1]] = 1'b1;
                end else if (out_ready) begin
                    m_ov = 1'b0;
                end
            end
        end
    endtask

    task automatic driver_loop();
        vec_t v;
        forever begin
            @(posedge clk);
            #1;
            if (acc_seen[0]) begin drv_q0.delete(0); acc_seen[0] = 1'b0; end
            if (acc_seen[1]) begin drv_q1.delete(0); acc_seen[1] = 1'b0; end
            rq_valid = 2'b00;
            clr_cnt  = 1'b0;
            if (drv_q0.size() != 0) begin
                v = vec[drv_q0[0].idx];
                rq_valid[0] = 1'b1;
                clr_cnt = drv_q0[0].clr;
                rq_mode[0] = v.mode;
                rq_intA[52:0] = v.iA;  rq_intB[52:0] = v.iB;
                rq_expA[10:0] = v.eA;  rq_expB[10:0] = v.eB;
                rq_flags[7:0] = v.fl;
            end
            if (drv_q1.size() != 0) begin
                v = vec[drv_q1[0].idx];
                rq_valid[1] = 1'b1;
                rq_mode[1] = v.mode;
                rq_intA[105:53] = v.iA;  rq_intB[105:53] = v.iB;
                rq_expA[21:11]  = v.eA;  rq_expB[21:11]  = v.eB;
                rq_flags[15:8]  = v.fl;
            end
        end
    endtask

    initial begin
        int n;
        vec[0] = '{1'b0, 53'h80_0000, 53'hC0_0000, 11'h07F, 11'h080, 8'h00,
                   64'h3F80_0000, 64'h4040_0000, 1'b0};
        vec[1] = '{1'b1, 53'h10_0000_0000_0000, 53'h18_0000_0000_0000, 11'h3FF, 11'h400, 8'h00,
                   64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 1'b0};
        vec[2] = '{1'b0, 53'h80_0000, 53'h80_0000, 11'h07F, 11'h07F, 8'h90,
                   64'hBF80_0000, 64'h7FC0_0000, 1'b0};
        vec[3] = '{1'b1, 53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 11'h3FF, 11'h3FF, 8'h88,
                   64'hFFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0};
        vec[4] = '{1'b0, 53'h80_0000, 53'h80_0000, 11'h07F, 11'h07F, 8'h02,
                   64'h3F80_0000, 64'h3F80_0000, 1'b1};
        vec[5] = '{1'b1, 53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 11'h3FF, 11'h3FF, 8'h01,
                   64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1};
        vec[6] = '{1'b0, 53'h1F_FFFF_FFFF_FFFF, 53'h0, 11'h7FE, 11'h000, 8'h40,
                   64'h7F7F_FFFF, 64'h8000_0000, 1'b0};
        vec[7] = '{1'b1, 53'h10_0000_0000_0000, 53'h0, 11'h3FF, 11'h000, 8'h50,
                   64'h3FF0_0000_0000_0000, 64'hFFF8_0000_0000_0000, 1'b0};

        n_checks = 0; n_fail = 0; cyc = 0; acc_seen = 2'b00;
        m_last = 1'b1; m_ov = 1'b0;
        rq_valid = 2'b00; rq_mode = 2'b00; rq_intA = '0; rq_intB = '0;
        rq_expA = '0; rq_expB = '0; rq_flags = '0; out_ready = 1'b1; clr_cnt = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_A", out_A, 64'd0);
        chk("rst_out_B", out_B, 64'd0);
        chk("rst_out_err", out_err, 1'b0);
        chk("rst_out_src", out_src, 1'b0);
        chk("rst_err_cnt0", err_cnt0, 16'd0);
        chk("rst_err_cnt1", err_cnt1, 16'd0);
        chk("rst_rq_ready", rq_ready, 2'b00);

        fork
            monitor_loop();
            driver_loop();
        join_none

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Contention: alternating grants at full rate, src0 first after reset
        src_log.delete(); cyc_log.delete();
        for (int i = 0; i < 3; i++) begin load(0, 0, 1'b0); load(1, 1, 1'b0); end
        wait_idle("t2_idle", 40);
        chk_seq("t2_order", 6, 8'h2A);
        if (cyc_log.size() == 6) chk("t2_throughput", 64'(cyc_log[5] - cyc_log[0]), 64'd5);

        // Backpressure: first bundle lands, then a 5-cycle stall holds it
        src_log.delete(); cyc_log.delete();
        out_ready = 1'b0;
        load(0, 2, 1'b0); load(0, 0, 1'b0); load(1, 3, 1'b0); load(1, 1, 1'b0);
        @(posedge clk); #2;
        repeat (5) begin
            @(posedge clk); #2;
            chk("t3_hold_A", out_A, vec[2].oA);
            chk("t3_hold_B", out_B, vec[2].oB);
            chk("t3_stall_ready", rq_ready, 2'b00);
        end
        out_ready = 1'b1;
        wait_idle("t3_idle", 40);
        chk_seq("t3_order", 4, 8'h0A);

        // Single source stream, then contention resumes with src0
        src_log.delete(); cyc_log.delete();
        load(1, 1, 1'b0); load(1, 6, 1'b0); load(1, 3, 1'b0); load(1, 7, 1'b0);
        wait_idle("t4_idle_a", 40);
        if (cyc_log.size() == 4) chk("t4_throughput", 64'(cyc_log[3] - cyc_log[0]), 64'd3);
        load(0, 0, 1'b0); load(1, 2, 1'b0);
        wait_idle("t4_idle_b", 40);
        chk_seq("t4_order", 6, 8'h2F);

        // Error counters, clear priority, and saturation on the 2-bit instance
        load(0, 4, 1'b0); load(0, 4, 1'b0); load(0, 4, 1'b0);
        wait_idle("t5_idle_a", 40);
        chk("t5_cnt0_3", err_cnt0, 16'd3);
        chk("t5_cnt1_0", err_cnt1, 16'd0);
        chk("t5_sat_cnt0_3", err_cnt0_2, 2'd3);
        load(0, 4, 1'b1);
        wait_idle("t5_idle_b", 40);
        chk("t5_clr_cnt0", err_cnt0, 16'd0);
        chk("t5_clr_sat_cnt0", err_cnt0_2, 2'd0);
        load(0, 4, 1'b0); load(0, 5, 1'b0); load(0, 4, 1'b0); load(0, 5, 1'b0); load(0, 4, 1'b0);
        load(1, 5, 1'b0);
        wait_idle("t5_idle_c", 60);
        chk("t5_cnt0_5", err_cnt0, 16'd5);
        chk("t5_sat_cnt0", err_cnt0_2, 2'd3);
        chk("t5_cnt1_1", err_cnt1, 16'd1);
        chk("t5_sat_cnt1_1", err_cnt1_2, 2'd1);

        // Mode mixing back-to-back
        src_log.delete(); cyc_log.delete();
        load(0, 0, 1'b0); load(1, 1, 1'b0);
        wait_idle("t6_idle", 40);
        chk("t6_count", 64'(src_log.size()), 64'd2);

        // Asynchronous reset with a held result
        src_log.delete(); cyc_log.delete();
        load(0, 6, 1'b0);
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!out_valid && n < 20);
        chk("t1_midstream_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_out_valid", out_valid, 1'b0);
        chk("t1_rst_cnt0", err_cnt0, 16'd0);
        chk("t1_rst_cnt1", err_cnt1, 16'd0);
        chk("t1_rst_out_A", out_A, 64'd0);
        chk("t1_rst_ready", rq_ready, 2'b00);
        load(0, 2, 1'b0); load(0, 7, 1'b0);
        load(1, 3, 1'b0); load(1, 0, 1'b0); load(1, 1, 1'b0);
        repeat (2) begin
            @(posedge clk); #2;
            chk("t1_rst_ready_held", rq_ready, 2'b00);
        end
        rst_n = 1'b1;
        wait_idle("t1_idle", 60);
        chk_seq("t1_order", 5, 8'h1A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
